mips_decode_stage: RTL and testbench
====================================

Name: mips_decode_stage

Overview:
- Pipelined successor to the combinational MIPS control decoder: decodes one instruction per cycle into a registered ID/EX control bundle.
- Adds a valid/ready handshake on both sides, load-use interlock, branch/jump flush, illegal-opcode flagging and a saturating stall counter.
- Sits between fetch (IF) and execute (EX) in the 5-stage core.

Parameters:
- PC_WIDTH, 32, width of PC fields; minimum 28.
- EXTENDED_OPS, 1, when 1 decodes slt, srl, ori, bne and j; when 0 these are illegal.
- LOAD_USE_INTERLOCK, 1, when 1 inserts a bubble on load-use hazards; when 0 never stalls for hazards.
- CNT_WIDTH, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_valid  in  1  if_instr and if_pc are valid.
- if_ready  out  1  stage accepts the input this cycle.
- if_instr  in  32  instruction word.
- if_pc  in  PC_WIDTH  PC of the instruction.
- flush  in  1  branch/jump redirect from EX.
- ex_ready  in  1  EX accepts ex_* this cycle.
- ex_valid  out  1  ex_* bundle is valid.
- ex_pc  out  PC_WIDTH  registered PC.
- ex_rs, ex_rt  out  5 each  source register addresses.
- ex_wr_addr  out  5  destination: rd for R-type, rt for I-type.
- ex_reg_write  out  1  register write enable.
- ex_mem_to_reg  out  1  writeback data comes from memory (lw).
- ex_mem_write  out  1  data memory write (sw).
- ex_alu_b_src  out  2  0 = immediate, 1 = rt, 2 = shamt.
- ex_alu_ctrl  out  4  ALU operation.
- ex_imm  out  32  extended immediate.
- ex_shamt  out  5  shift amount.
- ex_is_branch  out  1  beq or bne.
- ex_branch_ne  out  1  1 = bne.
- ex_is_jump  out  1  j.
- ex_jump_target  out  PC_WIDTH  {if_pc[PC_WIDTH-1:28], instr[25:0], 2'b00}.
- ex_illegal  out  1  unrecognised opcode or funct.
- stall_count  out  CNT_WIDTH  saturating count of hazard-stall cycles.

Behaviour:
- Reset (asynchronous, rst_n low): ex_valid = 0, stall_count = 0, every ex_* field = 0. if_ready is combinational and evaluates to 1 while in reset.
- Definitions:
  - adv = !ex_valid || ex_ready.
  - hazard = LOAD_USE_INTERLOCK && ex_valid && ex_mem_to_reg && ex_wr_addr != 0 && if_valid && the incoming instruction reads ex_wr_addr.
  - "Reads": rs for all non-jump instructions; rt additionally for R-type (sll/srl read rt only), sw, beq and bne.
- Handshake: if_ready = flush || (adv && !hazard). A transfer occurs when if_valid && if_ready.
- Latency is 1 cycle. On a transfer without flush, the bundle is registered and ex_valid = 1 next cycle.
- Hazard with adv: ex_valid <= 0 (bubble), the input is held, and stall_count increments, saturating at all-ones.
- !adv: all ex_* registers hold; no stall count.
- Flush has priority over everything:
  - ex_valid <= 0 next cycle.
  - if_ready = 1, and any presented input is discarded.
  - stall_count does not increment.
- Decode:
  - Opcode 0 (R-type), by funct:
    - add 0x20 → ALU 0010
    - sub 0x22 → 0110
    - and 0x24 → 0000
    - or 0x25 → 0001
    - slt 0x2A → 0111
    - sll 0x00 → 0011, alu_b_src = 2, rs field ignored
    - srl 0x02 → 0100, alu_b_src = 2, rs field ignored
  - lw 0x23 / sw 0x2B: ADD, sign-extended immediate.
  - addi 0x08: ADD, sign-extended immediate.
  - andi 0x0C / ori 0x0D: AND / OR, zero-extended immediate.
  - beq 0x04 / bne 0x05: SUB, alu_b_src = 1, sign-extended immediate.
  - j 0x02: is_jump = 1.
- Illegal opcode/funct, or an extended op when EXTENDED_OPS = 0:
  - ex_illegal = 1.
  - reg_write, mem_write, is_branch and is_jump all 0.
  - The instruction still flows (ex_valid = 1).
- ex_reg_write is forced to 0 when the destination is $0.
- nop (0x00000000) decodes as sll $0 and produces reg_write = 0, illegal = 0.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct constants;
  - ALU_CTRL codes (4-bit);
  - ALU_B_SRC codes (IMM = 0, RT = 1, SHAMT = 2).
- One sub-module, mips_decode_comb: a pure combinational instruction → control-bundle decoder.
- mips_decode_stage wraps mips_decode_comb with the hazard logic, pipeline register and counter.

Test Plan:
- Reset then single add:
  - Stimulus: rst_n pulsed low mid-run; then instr 0x012A4020 (add $8,$9,$10), ex_ready = 1.
  - Response: during reset, ex_valid = 0 and stall_count = 0. Next cycle: ex_valid = 1, alu_ctrl = 0010, wr_addr = 8, alu_b_src = 1, reg_write = 1.
- Load-use:
  - Stimulus: lw $8,4($9) (0x8D280004), then add $10,$8,$11.
  - Response: one bubble cycle with if_ready = 0, then add issues; stall_count = 1. The same sequence with add $10,$12,$11 causes no stall.
- Backpressure:
  - Stimulus: ex_ready = 0 for 3 cycles with ex_valid = 1.
  - Response: ex_* stable, if_ready = 0, stall_count unchanged.
- Flush:
  - Stimulus: flush = 1 while a valid instruction is presented.
  - Response: next cycle ex_valid = 0; that instruction never appears.
- Immediates:
  - Stimulus: andi with imm 0xFFFF; addi with imm 0xFFFF.
  - Response: andi gives ex_imm = 0x0000FFFF; addi gives ex_imm = 0xFFFFFFFF.
- EXTENDED_OPS = 0:
  - Stimulus: bne 0x15090003.
  - Response: ex_illegal = 1, is_branch = 0.
  - j 0x08000010 at if_pc 0x40000000 with EXTENDED_OPS = 1: ex_jump_target = 0x40000040.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, functs, ALU and ALU-B-source codes, control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALU_B_IMM   = 2'd0;
  localparam logic [1:0] ALU_B_RT    = 2'd1;
  localparam logic [1:0] ALU_B_SHAMT = 2'd2;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr_addr;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic [1:0]  alu_b_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        is_branch;
    logic        branch_ne;
    logic        is_jump;
    logic        illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_decode_comb.sv
// Pure combinational instruction -> control-bundle decoder, plus which source registers are read.
// Zero latency; no flow control of its own.
module mips_decode_comb
  import mips_pkg::*;
#(
  parameter int EXTENDED_OPS = 1
) (
  input  logic [31:0]       i_instr,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_reads_rs,
  output logic              o_reads_rt
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_legal;
  logic       w_ext;
  ctrl_t      w_c;

  assign w_op    = i_instr[31:26];
  assign w_funct = i_instr[5:0];
  assign w_ext   = (EXTENDED_OPS != 0);

  always_comb begin
    w_c           = '0;
    w_legal       = 1'b1;
    w_c.rs        = i_instr[25:21];
    w_c.rt        = i_instr[20:16];
    w_c.shamt     = i_instr[10:6];
    w_c.wr_addr   = (w_op == OP_RTYPE) ? i_instr[15:11] : i_instr[20:16];
    w_c.imm       = sext16(i_instr[15:0]);
    w_c.alu_b_src = ALU_B_IMM;
    w_c.alu_ctrl  = ALU_ADD;

    case (w_op)
      OP_RTYPE: begin
        w_c.reg_write = 1'b1;
        w_c.alu_b_src = ALU_B_RT;
        case (w_funct)
          F_ADD: w_c.alu_ctrl = ALU_ADD;
          F_SUB: w_c.alu_ctrl = ALU_SUB;
          F_AND: w_c.alu_ctrl = ALU_AND;
          F_OR:  w_c.alu_ctrl = ALU_OR;
          F_SLT: begin
            w_c.alu_ctrl = ALU_SLT;
            w_legal      = w_ext;
          end
          F_SLL: begin
            w_c.alu_ctrl  = ALU_SLL;
            w_c.alu_b_src = ALU_B_SHAMT;
          end
          F_SRL: begin
            w_c.alu_ctrl  = ALU_SRL;
            w_c.alu_b_src = ALU_B_SHAMT;
            w_legal       = w_ext;
          end
          default: w_legal = 1'b0;
        endcase
      end
      OP_LW: begin
        w_c.reg_write  = 1'b1;
        w_c.mem_to_reg = 1'b1;
      end
      OP_SW:   w_c.mem_write = 1'b1;
      OP_ADDI: w_c.reg_write = 1'b1;
      OP_ANDI: begin
        w_c.reg_write = 1'b1;
        w_c.alu_ctrl  = ALU_AND;
        w_c.imm       = {16'h0000, i_instr[15:0]};
      end
      OP_ORI: begin
        w_c.reg_write = 1'b1;
        w_c.alu_ctrl  = ALU_OR;
        w_c.imm       = {16'h0000, i_instr[15:0]};
        w_legal       = w_ext;
      end
      OP_BEQ: begin
        w_c.alu_ctrl  = ALU_SUB;
        w_c.alu_b_src = ALU_B_RT;
        w_c.is_branch = 1'b1;
      end
      OP_BNE: begin
        w_c.alu_ctrl  = ALU_SUB;
        w_c.alu_b_src = ALU_B_RT;
        w_c.is_branch = 1'b1;
        w_c.branch_ne = 1'b1;
        w_legal       = w_ext;
      end
      OP_J: begin
        w_c.is_jump = 1'b1;
        w_legal     = w_ext;
      end
      default: w_legal = 1'b0;
    endcase

    // Illegal instructions still flow down the pipe but must have no side effects.
    if (!w_legal) begin
      w_c.illegal    = 1'b1;
      w_c.reg_write  = 1'b0;
      w_c.mem_to_reg = 1'b0;
      w_c.mem_write  = 1'b0;
      w_c.is_branch  = 1'b0;
      w_c.branch_ne  = 1'b0;
      w_c.is_jump    = 1'b0;
    end
    if (w_c.wr_addr == 5'd0) begin
      w_c.reg_write = 1'b0;
    end
  end

  // Register-read usage follows the encoding format, independent of whether the op is enabled.
  assign o_reads_rs = (w_op != OP_J) &&
                      !((w_op == OP_RTYPE) && ((w_funct == F_SLL) || (w_funct == F_SRL)));
  assign o_reads_rt = (w_op == OP_RTYPE) || (w_op == OP_SW) ||
                      (w_op == OP_BEQ) || (w_op == OP_BNE);
  assign o_ctrl     = w_c;

endmodule

// File: rtl/mips_decode_stage.sv
// ID stage: decodes one instruction per cycle into a registered ID/EX bundle (1-cycle latency).
// Holds on !ex_ready, bubbles on load-use hazards, flush discards input and kills the bundle.
module mips_decode_stage
  import mips_pkg::*;
#(
  parameter int PC_WIDTH           = 32,
  parameter int EXTENDED_OPS       = 1,
  parameter int LOAD_USE_INTERLOCK = 1,
  parameter int CNT_WIDTH          = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_if_valid,
  output logic                 o_if_ready,
  input  logic [31:0]          i_if_instr,
  input  logic [PC_WIDTH-1:0]  i_if_pc,
  input  logic                 i_flush,
  input  logic                 i_ex_ready,
  output logic                 o_ex_valid,
  output logic [PC_WIDTH-1:0]  o_ex_pc,
  output logic [4:0]           o_ex_rs,
  output logic [4:0]           o_ex_rt,
  output logic [4:0]           o_ex_wr_addr,
  output logic                 o_ex_reg_write,
  output logic                 o_ex_mem_to_reg,
  output logic                 o_ex_mem_write,
  output logic [1:0]           o_ex_alu_b_src,
  output logic [3:0]           o_ex_alu_ctrl,
  output logic [31:0]          o_ex_imm,
  output logic [4:0]           o_ex_shamt,
  output logic                 o_ex_is_branch,
  output logic                 o_ex_branch_ne,
  output logic                 o_ex_is_jump,
  output logic [PC_WIDTH-1:0]  o_ex_jump_target,
  output logic                 o_ex_illegal,
  output logic [CNT_WIDTH-1:0] o_stall_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CTRL_W-1:0]   w_ctrl_bits;
  ctrl_t               w_ctrl;
  logic                w_reads_rs;
  logic                w_reads_rt;
  logic [PC_WIDTH-1:0] w_jump_target;
  logic                w_adv;
  logic                w_hazard;
  logic                w_src_match;

  logic                 r_valid;
  ctrl_t                r_ctrl;
  logic [PC_WIDTH-1:0]  r_pc;
  logic [PC_WIDTH-1:0]  r_jump_target;
  logic [CNT_WIDTH-1:0] r_stall_cnt;

  mips_decode_comb #(
    .EXTENDED_OPS(EXTENDED_OPS)
  ) u_decode (
    .i_instr    (i_if_instr),
    .o_ctrl     (w_ctrl_bits),
    .o_reads_rs (w_reads_rs),
    .o_reads_rt (w_reads_rt)
  );

  assign w_ctrl = ctrl_t'(w_ctrl_bits);

  generate
    if (PC_WIDTH > 28) begin : g_jt_region
      assign w_jump_target = {i_if_pc[PC_WIDTH-1:28], i_if_instr[25:0], 2'b00};
    end else begin : g_jt_flat
      assign w_jump_target = {i_if_instr[25:0], 2'b00};
    end
  endgenerate

  assign w_adv       = !r_valid || i_ex_ready;
  assign w_src_match = (w_reads_rs && (w_ctrl.rs == r_ctrl.wr_addr)) ||
                       (w_reads_rt && (w_ctrl.rt == r_ctrl.wr_addr));
  assign w_hazard    = (LOAD_USE_INTERLOCK != 0) && r_valid && r_ctrl.mem_to_reg &&
                       (r_ctrl.wr_addr != 5'd0) && i_if_valid && w_src_match;
  assign o_if_ready  = i_flush || (w_adv && !w_hazard);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid       <= 1'b0;
      r_ctrl        <= '0;
      r_pc          <= '0;
      r_jump_target <= '0;
      r_stall_cnt   <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_adv) begin
      if (w_hazard) begin
        r_valid <= 1'b0;
        if (r_stall_cnt != CNT_MAX) begin
          r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
      end else if (i_if_valid) begin
        r_valid       <= 1'b1;
        r_ctrl        <= w_ctrl;
        r_pc          <= i_if_pc;
        r_jump_target <= w_jump_target;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_ex_valid       = r_valid;
  assign o_ex_pc          = r_pc;
  assign o_ex_rs          = r_ctrl.rs;
  assign o_ex_rt          = r_ctrl.rt;
  assign o_ex_wr_addr     = r_ctrl.wr_addr;
  assign o_ex_reg_write   = r_ctrl.reg_write;
  assign o_ex_mem_to_reg  = r_ctrl.mem_to_reg;
  assign o_ex_mem_write   = r_ctrl.mem_write;
  assign o_ex_alu_b_src   = r_ctrl.alu_b_src;
  assign o_ex_alu_ctrl    = r_ctrl.alu_ctrl;
  assign o_ex_imm         = r_ctrl.imm;
  assign o_ex_shamt       = r_ctrl.shamt;
  assign o_ex_is_branch   = r_ctrl.is_branch;
  assign o_ex_branch_ne   = r_ctrl.branch_ne;
  assign o_ex_is_jump     = r_ctrl.is_jump;
  assign o_ex_jump_target = r_jump_target;
  assign o_ex_illegal     = r_ctrl.illegal;
  assign o_stall_count    = r_stall_cnt;

endmodule

// File: tb/tb_mips_decode_stage.sv
// Directed + randomized bench for mips_decode_stage against a behavioural pipeline/decode model.
module tb_mips_decode_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs, rt, wr;
    logic        regw, m2r, mw;
    logic [1:0]  bsrc;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic        br, bne, jmp;
    logic [31:0] jt;
    logic        ill, care_alu, care_imm;
  } exp_t;

  logic        clk, rst_n, if_valid, flush, ex_ready;
  logic [31:0] if_instr, if_pc;

  logic        if_ready, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write;
  logic [31:0] ex_pc, ex_imm, ex_jump_target;
  logic [4:0]  ex_rs, ex_rt, ex_wr_addr, ex_shamt;
  logic [1:0]  ex_alu_b_src;
  logic [3:0]  ex_alu_ctrl;
  logic        ex_is_branch, ex_branch_ne, ex_is_jump, ex_illegal;
  logic [15:0] stall_count;

  logic        if_ready_0, ex_valid_0, ex_reg_write_0, ex_mem_to_reg_0, ex_mem_write_0;
  logic [31:0] ex_pc_0, ex_imm_0, ex_jump_target_0;
  logic [4:0]  ex_rs_0, ex_rt_0, ex_wr_addr_0, ex_shamt_0;
  logic [1:0]  ex_alu_b_src_0;
  logic [3:0]  ex_alu_ctrl_0;
  logic        ex_is_branch_0, ex_branch_ne_0, ex_is_jump_0, ex_illegal_0;
  logic [15:0] stall_count_0;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t m;
  int   mcnt;

  mips_decode_stage dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_valid(if_valid), .o_if_ready(if_ready),
    .i_if_instr(if_instr), .i_if_pc(if_pc), .i_flush(flush), .i_ex_ready(ex_ready),
    .o_ex_valid(ex_valid), .o_ex_pc(ex_pc), .o_ex_rs(ex_rs), .o_ex_rt(ex_rt),
    .o_ex_wr_addr(ex_wr_addr), .o_ex_reg_write(ex_reg_write), .o_ex_mem_to_reg(ex_mem_to_reg),
    .o_ex_mem_write(ex_mem_write), .o_ex_alu_b_src(ex_alu_b_src), .o_ex_alu_ctrl(ex_alu_ctrl),
    .o_ex_imm(ex_imm), .o_ex_shamt(ex_shamt), .o_ex_is_branch(ex_is_branch),
    .o_ex_branch_ne(ex_branch_ne), .o_ex_is_jump(ex_is_jump), .o_ex_jump_target(ex_jump_target),
    .o_ex_illegal(ex_illegal), .o_stall_count(stall_count)
  );

  mips_decode_stage #(.EXTENDED_OPS(0)) dut_base (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_valid(if_valid), .o_if_ready(if_ready_0),
    .i_if_instr(if_instr), .i_if_pc(if_pc), .i_flush(flush), .i_ex_ready(ex_ready),
    .o_ex_valid(ex_valid_0), .o_ex_pc(ex_pc_0), .o_ex_rs(ex_rs_0), .o_ex_rt(ex_rt_0),
    .o_ex_wr_addr(ex_wr_addr_0), .o_ex_reg_write(ex_reg_write_0),
    .o_ex_mem_to_reg(ex_mem_to_reg_0), .o_ex_mem_write(ex_mem_write_0),
    .o_ex_alu_b_src(ex_alu_b_src_0), .o_ex_alu_ctrl(ex_alu_ctrl_0), .o_ex_imm(ex_imm_0),
    .o_ex_shamt(ex_shamt_0), .o_ex_is_branch(ex_is_branch_0), .o_ex_branch_ne(ex_branch_ne_0),
    .o_ex_is_jump(ex_is_jump_0), .o_ex_jump_target(ex_jump_target_0),
    .o_ex_illegal(ex_illegal_0), .o_stall_count(stall_count_0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference decode straight from the instruction-set table.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc, input bit ext);
    exp_t e;
    int   op, fn;
    bit   legal;
    logic [31:0] imm_s, imm_z;
    op    = int'(ins[31:26]);
    fn    = int'(ins[5:0]);
    legal = 1'b1;
    imm_s = {{16{ins[15]}}, ins[15:0]};
    imm_z = {16'h0, ins[15:0]};
    e       = '0;
    e.valid = 1'b1;
    e.pc    = pc;
    e.rs    = ins[25:21];
    e.rt    = ins[20:16];
    e.shamt = ins[10:6];
    e.wr    = (op == 0) ? ins[15:11] : ins[20:16];
    e.jt    = {pc[31:28], ins[25:0], 2'b00};
    case (op)
      'h00: begin
        e.regw = 1; e.bsrc = 1;
        case (fn)
          'h20: e.alu = 2;
          'h22: e.alu = 6;
          'h24: e.alu = 0;
          'h25: e.alu = 1;
          'h2A: if (ext) e.alu = 7; else legal = 0;
          'h00: begin e.alu = 3; e.bsrc = 2; end
          'h02: if (ext) begin e.alu = 4; e.bsrc = 2; end else legal = 0;
          default: legal = 0;
        endcase
      end
      'h23: begin e.regw = 1; e.m2r = 1; e.alu = 2; e.bsrc = 0; e.imm = imm_s; e.care_imm = 1; end
      'h2B: begin e.mw = 1; e.alu = 2; e.bsrc = 0; e.imm = imm_s; e.care_imm = 1; end
      'h08: begin e.regw = 1; e.alu = 2; e.bsrc = 0; e.imm = imm_s; e.care_imm = 1; end
      'h0C: begin e.regw = 1; e.alu = 0; e.bsrc = 0; e.imm = imm_z; e.care_imm = 1; end
      'h0D: if (ext) begin e.regw = 1; e.alu = 1; e.bsrc = 0; e.imm = imm_z; e.care_imm = 1; end
            else legal = 0;
      'h04: begin e.br = 1; e.alu = 6; e.bsrc = 1; e.imm = imm_s; e.care_imm = 1; end
      'h05: if (ext) begin e.br = 1; e.bne = 1; e.alu = 6; e.bsrc = 1; e.imm = imm_s; e.care_imm = 1; end
            else legal = 0;
      'h02: if (ext) e.jmp = 1; else legal = 0;
      default: legal = 0;
    endcase
    if (!legal) begin
      e.ill = 1; e.regw = 0; e.m2r = 0; e.mw = 0; e.br = 0; e.bne = 0; e.jmp = 0; e.care_imm = 0;
    end
    e.care_alu = legal && !e.jmp;
    if (e.wr == 0) e.regw = 0;
    return e;
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    int op, fn;
    bit rs_used, rt_used;
    op      = int'(ins[31:26]);
    fn      = int'(ins[5:0]);
    rs_used = (op != 2) && !(op == 0 && (fn == 0 || fn == 2));
    rt_used = (op == 0) || (op == 'h2B) || (op == 4) || (op == 5);
    return (rs_used && ins[25:21] == r) || (rt_used && ins[20:16] == r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [12];
    logic [5:0] fns [8];
    logic [5:0] op, fn;
    logic [31:0] ins;
    ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h04, 6'h05, 6'h02};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02, 6'h3F};
    op  = ($urandom_range(0, 15) < 12) ? ops[$urandom_range(0, 11)] : 6'($urandom);
    fn  = fns[$urandom_range(0, 7)];
    ins = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
    if (op == 6'h00) ins[5:0] = fn;
    return ins;
  endfunction

  task automatic check_outputs();
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    chk("stall_count", 32'(stall_count), 32'(mcnt));
    if (m.valid) begin
      chk("ex_pc", ex_pc, m.pc);
      chk("ex_rs", 32'(ex_rs), 32'(m.rs));
      chk("ex_rt", 32'(ex_rt), 32'(m.rt));
      chk("ex_wr_addr", 32'(ex_wr_addr), 32'(m.wr));
      chk("ex_reg_write", 32'(ex_reg_write), 32'(m.regw));
      chk("ex_mem_to_reg", 32'(ex_mem_to_reg), 32'(m.m2r));
      chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
      chk("ex_shamt", 32'(ex_shamt), 32'(m.shamt));
      chk("ex_is_branch", 32'(ex_is_branch), 32'(m.br));
      chk("ex_branch_ne", 32'(ex_branch_ne), 32'(m.bne));
      chk("ex_is_jump", 32'(ex_is_jump), 32'(m.jmp));
      chk("ex_jump_target", ex_jump_target, m.jt);
      chk("ex_illegal", 32'(ex_illegal), 32'(m.ill));
      if (m.care_alu) begin
        chk("ex_alu_ctrl", 32'(ex_alu_ctrl), 32'(m.alu));
        chk("ex_alu_b_src", 32'(ex_alu_b_src), 32'(m.bsrc));
      end
      if (m.care_imm) chk("ex_imm", ex_imm, m.imm);
    end
  endtask

  // One cycle: drive at negedge, check if_ready before the edge, check the bundle at next negedge.
  task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                      input bit fl, input bit er);
    bit adv, hz;
    if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = er;
    #1;
    adv = !m.valid || er;
    hz  = v && m.valid && m.m2r && (m.wr != 0) && reads_reg(ins, m.wr);
    chk("if_ready", 32'(if_ready), 32'(fl || (adv && !hz)));
    @(posedge clk);
    if (fl) m.valid = 0;
    else if (adv) begin
      if (hz) begin
        m.valid = 0;
        if (mcnt != 65535) mcnt++;
      end else if (v) m = ref_decode(ins, pc, 1'b1);
      else m.valid = 0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'd1);
    chk({tag, "_ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, "_stall_count"}, 32'(stall_count), 32'd0);
    chk({tag, "_ex_pc"}, ex_pc, 32'd0);
    chk({tag, "_ex_imm"}, ex_imm, 32'd0);
  endtask

  logic [31:0] held_pc;
  logic [15:0] held_cnt;

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b1;
    m = '0; mcnt = 0;
    @(negedge clk); @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;

    step(1, 32'h012A4020, 32'h0000_0100, 0, 1);
    chk("add_valid", 32'(ex_valid), 32'd1);
    chk("add_alu", 32'(ex_alu_ctrl), 32'b0010);
    chk("add_wr", 32'(ex_wr_addr), 32'd8);
    chk("add_bsrc", 32'(ex_alu_b_src), 32'd1);
    chk("add_regw", 32'(ex_reg_write), 32'd1);

    step(1, 32'h8D280004, 32'h0000_0104, 0, 1);
    step(1, 32'h010B5020, 32'h0000_0108, 0, 1);
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_cnt", 32'(stall_count), 32'd1);
    step(1, 32'h010B5020, 32'h0000_0108, 0, 1);
    chk("lu_issue_wr", 32'(ex_wr_addr), 32'd10);
    step(1, 32'h8D280004, 32'h0000_010C, 0, 1);
    step(1, 32'h018B5020, 32'h0000_0110, 0, 1);
    chk("nolu_valid", 32'(ex_valid), 32'd1);
    chk("nolu_cnt", 32'(stall_count), 32'd1);

    held_pc  = ex_pc;
    held_cnt = stall_count;
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h2128FFFF, 32'h0000_0114, 0, 0);
      chk("bp_if_ready", 32'(if_ready), 32'd0);
      chk("bp_pc", ex_pc, held_pc);
      chk("bp_cnt", 32'(stall_count), 32'(held_cnt));
    end
    step(1, 32'h2128FFFF, 32'h0000_0114, 0, 1);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFF);

    step(1, 32'h012A4020, 32'h0000_0200, 1, 1);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    step(0, 32'h0, 32'h0, 0, 1);
    chk("flush_gone", 32'(ex_valid), 32'd0);

    step(1, 32'h3128FFFF, 32'h0000_0300, 0, 1);
    chk("andi_imm", ex_imm, 32'h0000_FFFF);
    step(1, 32'h08000010, 32'h4000_0000, 0, 1);
    chk("j_target", ex_jump_target, 32'h4000_0040);
    chk("j_is_jump", 32'(ex_is_jump), 32'd1);
    step(1, 32'h15090003, 32'h0000_0304, 0, 1);
    chk("bne_ext1_br", 32'(ex_is_branch), 32'd1);
    chk("bne_ext0_illegal", 32'(ex_illegal_0), 32'd1);
    chk("bne_ext0_branch", 32'(ex_is_branch_0), 32'd0);
    chk("bne_ext0_valid", 32'(ex_valid_0), 32'd1);
    step(1, 32'h0000_0000, 32'h0000_0308, 0, 1);
    chk("nop_regw", 32'(ex_reg_write), 32'd0);
    chk("nop_illegal", 32'(ex_illegal), 32'd0);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 4) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);

    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("midreset");
    m = '0; mcnt = 0;
    if_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 4) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
